// File: rtl/video_pkg.sv
// Shared video definitions: CRC-32 constants, RGB pixel type, sink FSM
// state encodings and sticky error-bit positions.
// No logic, so no latency or backpressure applies.
package video_pkg;

  localparam logic [31:0] CRC32_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] CRC32_INIT = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  // Sink FSM state encoding
  typedef logic [0:0] sink_state_t;
  localparam sink_state_t ST_WAIT_SOF = 1'b0;
  localparam sink_state_t ST_IN_FRAME = 1'b1;

  // Sticky error flag bit positions
  localparam int ERR_NO_SOF     = 0;  // beat accepted before any SOF
  localparam int ERR_EARLY_LAST = 1;  // tlast before the last pixel of a line
  localparam int ERR_MISS_LAST  = 2;  // last pixel of a line without tlast
  localparam int ERR_SOF_MID    = 3;  // SOF while a frame is in progress

endpackage

// File: rtl/crc32_step.sv
// Next CRC-32 state after shifting DATA_W data bits in, MSB first (non-reflected).
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is registered.
// Ports: i_crc current CRC state, i_data beat data, o_crc updated CRC state.
module crc32_step
  import video_pkg::*;
#(
  parameter int DATA_W = 24
) (
  input  logic [31:0]       i_crc,
  input  logic [DATA_W-1:0] i_data,
  output logic [31:0]       o_crc
);

  logic [31:0] w_c;

  always_comb begin
    w_c = i_crc;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (w_c[31] ^ i_data[i]) begin
        w_c = {w_c[30:0], 1'b0} ^ CRC32_POLY;
      end else begin
        w_c = {w_c[30:0], 1'b0};
      end
    end
    o_crc = w_c;
  end

endmodule

// File: rtl/axis_video_sink.sv
// AXI-Stream RGB video sink: checks SOF/EOL framing and computes a per-frame CRC-32.
// Latency: frame_done / frame_crc appear one cycle after the edge accepting the last pixel.
// Backpressure: tready = enable & ~clear & ready_pattern[phase], never a function of tvalid.
// Ports: s_axis_* stream input; enable/clear/ready_pattern control; frame_done,
//        frame_crc, frame_count, beat_count, line_idx, pixel_idx, err_flags status.
module axis_video_sink
  import video_pkg::*;
#(
  parameter int FRAME_WIDTH  = 32,
  parameter int FRAME_HEIGHT = 24,
  parameter int DATA_W       = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  input  logic              s_axis_tuser,
  output logic              s_axis_tready,
  input  logic              enable,
  input  logic              clear,
  input  logic [15:0]       ready_pattern,
  output logic              frame_done,
  output logic [31:0]       frame_crc,
  output logic [31:0]       frame_count,
  output logic [31:0]       beat_count,
  output logic [15:0]       line_idx,
  output logic [15:0]       pixel_idx,
  output logic [3:0]        err_flags
);

  localparam logic [15:0] LAST_PIX  = 16'(FRAME_WIDTH - 1);
  localparam logic [15:0] LAST_LINE = 16'(FRAME_HEIGHT - 1);

  logic        r_rdy_en;
  logic [3:0]  r_phase;
  sink_state_t r_state;
  logic [31:0] r_crc;
  logic [31:0] r_frame_crc;
  logic [31:0] r_frame_count;
  logic [31:0] r_beat_count;
  logic [15:0] r_line;
  logic [15:0] r_pix;
  logic [3:0]  r_err;
  logic        r_done;

  logic        w_accept;
  logic        w_eol;
  logic        w_last_line;
  logic [31:0] w_crc_seed;
  logic [31:0] w_crc_next;

  // r_rdy_en holds tready low while in reset regardless of enable/pattern.
  assign s_axis_tready = r_rdy_en & enable & ~clear & ready_pattern[r_phase];
  assign w_accept      = s_axis_tvalid & s_axis_tready;
  assign w_eol         = (r_pix == LAST_PIX);
  assign w_last_line   = (r_line == LAST_LINE);

  // Any SOF beat restarts the CRC, whether it opens a frame or interrupts one.
  assign w_crc_seed = ((r_state == ST_WAIT_SOF) || s_axis_tuser) ? CRC32_INIT : r_crc;

  crc32_step #(.DATA_W(DATA_W)) u_crc (
    .i_crc  (w_crc_seed),
    .i_data (s_axis_tdata),
    .o_crc  (w_crc_next)
  );

  // Backpressure phase: free-running, untouched by clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdy_en <= 1'b0;
      r_phase  <= 4'd0;
    end else begin
      r_rdy_en <= 1'b1;
      r_phase  <= r_phase + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_WAIT_SOF;
      r_crc         <= CRC32_INIT;
      r_frame_crc   <= 32'd0;
      r_frame_count <= 32'd0;
      r_beat_count  <= 32'd0;
      r_line        <= 16'd0;
      r_pix         <= 16'd0;
      r_err         <= 4'd0;
      r_done        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (clear) begin
        r_state       <= ST_WAIT_SOF;
        r_crc         <= CRC32_INIT;
        r_frame_crc   <= 32'd0;
        r_frame_count <= 32'd0;
        r_beat_count  <= 32'd0;
        r_line        <= 16'd0;
        r_pix         <= 16'd0;
        r_err         <= 4'd0;
      end else if (w_accept) begin
        r_beat_count <= r_beat_count + 32'd1;
        if (s_axis_tuser) begin
          // SOF always (re)starts a frame with this beat as pixel 0.
          if (r_state == ST_IN_FRAME) begin
            r_err[ERR_SOF_MID] <= 1'b1;
          end
          r_crc   <= w_crc_next;
          r_pix   <= 16'd1;
          r_line  <= 16'd0;
          r_state <= ST_IN_FRAME;
        end else if (r_state == ST_WAIT_SOF) begin
          r_err[ERR_NO_SOF] <= 1'b1;
        end else begin
          r_crc <= w_crc_next;
          if (w_eol) begin
            // Geometry wins over tlast: the line ends here either way.
            if (!s_axis_tlast) begin
              r_err[ERR_MISS_LAST] <= 1'b1;
            end
            r_pix <= 16'd0;
            if (w_last_line) begin
              r_frame_crc   <= ~w_crc_next;
              r_done        <= 1'b1;
              r_frame_count <= r_frame_count + 32'd1;
              r_line        <= 16'd0;
              r_state       <= ST_WAIT_SOF;
            end else begin
              r_line <= r_line + 16'd1;
            end
          end else begin
            if (s_axis_tlast) begin
              r_err[ERR_EARLY_LAST] <= 1'b1;
            end
            r_pix <= r_pix + 16'd1;
          end
        end
      end
    end
  end

  assign frame_done  = r_done;
  assign frame_crc   = r_frame_crc;
  assign frame_count = r_frame_count;
  assign beat_count  = r_beat_count;
  assign line_idx    = r_line;
  assign pixel_idx   = r_pix;
  assign err_flags   = r_err;

endmodule

// File: tb/tb_axis_video_sink.sv
module tb_axis_video_sink;

  localparam int W  = 32;
  localparam int H  = 24;
  localparam int DW = 24;
  localparam logic [31:0] POLY = 32'h04C11DB7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tuser = 1'b0;
  logic          s_axis_tready;
  logic          enable = 1'b1;
  logic          clear = 1'b0;
  logic [15:0]   ready_pattern = 16'hFFFF;
  logic          frame_done;
  logic [31:0]   frame_crc;
  logic [31:0]   frame_count;
  logic [31:0]   beat_count;
  logic [15:0]   line_idx;
  logic [15:0]   pixel_idx;
  logic [3:0]    err_flags;

  always #5 clk = ~clk;

  axis_video_sink #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H), .DATA_W(DW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tready (s_axis_tready),
    .enable        (enable),
    .clear         (clear),
    .ready_pattern (ready_pattern),
    .frame_done    (frame_done),
    .frame_crc     (frame_crc),
    .frame_count   (frame_count),
    .beat_count    (beat_count),
    .line_idx      (line_idx),
    .pixel_idx     (pixel_idx),
    .err_flags     (err_flags)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] crc;
    logic [31:0] fc;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;

  logic [31:0] ref_crc;

  // Expected backpressure phase and post-reset readiness
  logic [3:0] ph = 4'd0;
  logic       m_en = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph   <= 4'd0;
      m_en <= 1'b0;
    end else begin
      ph   <= ph + 4'd1;
      m_en <= 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Byte-at-a-time MSB-first CRC-32 update over a 24-bit beat
  function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [23:0] d);
    logic [31:0] c;
    c = c_in;
    for (int b = 2; b >= 0; b--) begin
      c = c ^ {d[8*b +: 8], 24'h0};
      for (int k = 0; k < 8; k++) begin
        c = c[31] ? ((c << 1) ^ POLY) : (c << 1);
      end
    end
    return c;
  endfunction

  function automatic logic [23:0] pix(input int line, input int x);
    return {8'(x * 5 + 3), 8'(line * 11 + 1), 8'(x ^ (line * 4))};
  endfunction

  // Monitor: readiness every cycle, scoreboard pop on each frame_done
  always @(negedge clk) begin
    chk("tready", {31'd0, s_axis_tready}, {31'd0, m_en & enable & ~clear & ready_pattern[ph]});
    if (frame_done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame_done: got frame_done=1 expected none (frame_count=%0d)", frame_count);
      end else begin
        e = exp_q.pop_front();
        chk("frame_crc", frame_crc, e.crc);
        chk("frame_count_at_done", frame_count, e.fc);
      end
    end
  end

  task automatic send_beat(input logic [23:0] d, input logic u, input logic l);
    bit acc;
    int n;
    s_axis_tdata  = d;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    acc = 0;
    n   = 0;
    while (!acc && n < 64) begin
      @(negedge clk);
      acc = s_axis_tready;
      @(posedge clk);
      #1;
      n++;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tuser  = 1'b0;
    s_axis_tlast  = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: got no accept in 64 cycles expected accept (data %h)", d);
    end
  endtask

  // mode 1: tlast moved from pixel 31 to pixel 30 on line 5
  task automatic send_frame(input int n, input int mode, input logic [31:0] fc);
    exp_t x_e;
    logic l;
    if (n == W * H) begin
      x_e.crc = ref_crc;
      x_e.fc  = fc;
      exp_q.push_back(x_e);
    end
    for (int i = 0; i < n; i++) begin
      l = ((i % W) == W - 1);
      if (mode == 1 && (i / W) == 5 && (i % W) == 30) l = 1'b1;
      if (mode == 1 && (i / W) == 5 && (i % W) == 31) l = 1'b0;
      send_beat(pix(i / W, i % W), (i == 0), l);
    end
  endtask

  task automatic idle(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_frame_count"}, frame_count, 32'd0);
    chk({tag, "_beat_count"}, beat_count, 32'd0);
    chk({tag, "_frame_crc"}, frame_crc, 32'd0);
    chk({tag, "_err"}, {28'd0, err_flags}, 32'd0);
    chk({tag, "_idx"}, {line_idx, pixel_idx}, 32'd0);
    chk({tag, "_done"}, {31'd0, frame_done}, 32'd0);
  endtask

  task automatic check_status(input string tag, input int beats, input int fc, input logic [3:0] err);
    chk({tag, "_beat_count"}, beat_count, 32'(beats));
    chk({tag, "_frame_count"}, frame_count, 32'(fc));
    chk({tag, "_err"}, {28'd0, err_flags}, {28'd0, err});
    chk({tag, "_idx"}, {line_idx, pixel_idx}, 32'd0);
    chk({tag, "_done_low"}, {31'd0, frame_done}, 32'd0);
    chk({tag, "_sb_pending"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    logic [31:0] c;
    // Model sanity: CRC-32/BZIP2 of "123456789" packed as three 24-bit beats
    c = 32'hFFFFFFFF;
    c = crc_upd(c, 24'h313233);
    c = crc_upd(c, 24'h343536);
    c = crc_upd(c, 24'h373839);
    chk("crc_model_check", ~c, 32'hFC891918);

    c = 32'hFFFFFFFF;
    for (int l = 0; l < H; l++)
      for (int x = 0; x < W; x++)
        c = crc_upd(c, pix(l, x));
    ref_crc = ~c;

    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    chk("reset_tready", {31'd0, s_axis_tready}, 32'd0);
    rst_n = 1'b1;
    idle(1);

    // 1: clean frame, full readiness
    send_frame(W * H, 0, 1);
    idle(4);
    check_status("t1", 768, 1, 4'b0000);
    do_clear();
    check_zero("t1_clear");

    // 2: same frame under 16'hA5A5 backpressure
    ready_pattern = 16'hA5A5;
    send_frame(W * H, 0, 1);
    idle(4);
    check_status("t2", 768, 1, 4'b0000);
    ready_pattern = 16'hFFFF;
    do_clear();

    // 3: three beats before SOF, then a clean frame
    for (int k = 0; k < 3; k++) send_beat(pix(0, k), 1'b0, 1'b0);
    send_frame(W * H, 0, 1);
    idle(4);
    check_status("t3", 771, 1, 4'b0001);
    do_clear();

    // 4: tlast on pixel 30 of line 5, missing on pixel 31
    send_frame(W * H, 1, 1);
    idle(4);
    check_status("t4", 768, 1, 4'b0110);
    do_clear();

    // 5: SOF at line 10 pixel 0 of an active frame, then a full frame
    send_frame(10 * W, 0, 0);
    chk("t5_mid_idx", {line_idx, pixel_idx}, {16'd10, 16'd0});
    send_frame(W * H, 0, 1);
    idle(4);
    check_status("t5", 1088, 1, 4'b1000);
    do_clear();

    // 6: reset during line 12, clear mid-frame, then a clean frame
    send_frame(12 * W + 5, 0, 0);
    chk("t6_mid_idx", {line_idx, pixel_idx}, {16'd12, 16'd5});
    rst_n = 1'b0;
    idle(2);
    check_zero("t6_reset");
    chk("t6_reset_tready", {31'd0, s_axis_tready}, 32'd0);
    rst_n = 1'b1;
    idle(1);
    send_frame(W + 8, 0, 0);
    chk("t6_partial_idx", {line_idx, pixel_idx}, {16'd1, 16'd8});
    chk("t6_partial_beats", beat_count, 32'd40);
    do_clear();
    check_zero("t6_clear");
    send_frame(W * H, 0, 1);
    idle(4);
    check_status("t6", 768, 1, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
